// File: rtl/logical_issue_unit_if.sv
// Request/response channel bundle between the dispatch stage, the logical issue
// unit and the writeback stage.
interface logical_issue_unit_if #(
  parameter int WORD_SIZE   = 19,
  parameter int OPCODE_SIZE = 5
);
  // Both channels use valid/ready: a transfer happens on a rising edge where
  // valid && ready are both 1. The sender holds its payload stable while valid is
  // high and ready is low. ready never depends combinationally on valid.
  logic                   req_valid;
  logic                   req_ready;
  logic [OPCODE_SIZE-1:0] req_opcode;
  logic [WORD_SIZE-1:0]   req_op1;
  logic [WORD_SIZE-1:0]   req_op2;
  logic                   flush;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [WORD_SIZE-1:0]   rsp_result;
  logic                   rsp_zero;
  logic                   rsp_illegal;

  modport master (
    output req_valid, req_opcode, req_op1, req_op2, flush, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_illegal
  );

  modport slave (
    input  req_valid, req_opcode, req_op1, req_op2, flush, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_illegal
  );
endinterface

// File: rtl/logical_issue_unit.sv
// Logical issue unit: combinational AND/OR/XOR/NOT datapath feeding a small
// in-order response FIFO, with illegal-opcode flagging and debug counters.
module logical_unit #(
  parameter int WORD_SIZE   = 19,
  parameter int OPCODE_SIZE = 5
) (
  input  logic [OPCODE_SIZE-1:0] i_opcode,
  input  logic [WORD_SIZE-1:0]   i_op1,
  input  logic [WORD_SIZE-1:0]   i_op2,
  output logic [WORD_SIZE-1:0]   o_result,
  output logic                   o_zero,
  output logic                   o_illegal
);
  localparam logic [OPCODE_SIZE-1:0] OP_AND = OPCODE_SIZE'(0);
  localparam logic [OPCODE_SIZE-1:0] OP_OR  = OPCODE_SIZE'(1);
  localparam logic [OPCODE_SIZE-1:0] OP_XOR = OPCODE_SIZE'(2);
  localparam logic [OPCODE_SIZE-1:0] OP_NOT = OPCODE_SIZE'(3);

  always_comb begin
    o_result  = '0;
    o_illegal = 1'b0;
    case (i_opcode)
      OP_AND:  o_result = i_op1 & i_op2;
      OP_OR:   o_result = i_op1 | i_op2;
      OP_XOR:  o_result = i_op1 ^ i_op2;
      OP_NOT:  o_result = ~i_op1;
      default: o_illegal = 1'b1;
    endcase
  end

  assign o_zero = (o_result == '0);
endmodule

module logical_issue_unit #(
  parameter int WORD_SIZE   = 19,
  parameter int OPCODE_SIZE = 5,
  parameter int DEPTH       = 2,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  logical_issue_unit_if.slave  bus,
  output logic [CNT_W-1:0]     done_count,
  output logic [CNT_W-1:0]     illegal_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [CW-1:0]        r_count;
  logic [PW-1:0]        r_rd_ptr;
  logic [PW-1:0]        r_wr_ptr;
  logic [WORD_SIZE-1:0] r_res  [DEPTH];
  logic                 r_zero [DEPTH];
  logic                 r_ill  [DEPTH];
  logic [CNT_W-1:0]     r_done_cnt;
  logic [CNT_W-1:0]     r_ill_cnt;

  logic [WORD_SIZE-1:0] w_result;
  logic                 w_zero;
  logic                 w_illegal;
  logic                 w_push;
  logic                 w_pop;

  logical_unit #(
    .WORD_SIZE   (WORD_SIZE),
    .OPCODE_SIZE (OPCODE_SIZE)
  ) u_logical_unit (
    .i_opcode  (bus.req_opcode),
    .i_op1     (bus.req_op1),
    .i_op2     (bus.req_op2),
    .o_result  (w_result),
    .o_zero    (w_zero),
    .o_illegal (w_illegal)
  );

  // Flush wins over both handshakes: a same-cycle push or pop is discarded.
  assign bus.req_ready = !rst && (r_count != FULL);
  assign bus.rsp_valid = (r_count != '0);
  assign w_push        = bus.req_valid && bus.req_ready && !bus.flush;
  assign w_pop         = bus.rsp_valid && bus.rsp_ready && !bus.flush;

  // Head fields are gated so an empty FIFO presents all-zero outputs.
  assign bus.rsp_result  = bus.rsp_valid ? r_res[r_rd_ptr]  : '0;
  assign bus.rsp_zero    = bus.rsp_valid ? r_zero[r_rd_ptr] : 1'b0;
  assign bus.rsp_illegal = bus.rsp_valid ? r_ill[r_rd_ptr]  : 1'b0;

  assign done_count    = r_done_cnt;
  assign illegal_count = r_ill_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_done_cnt <= '0;
      r_ill_cnt  <= '0;
    end else if (bus.flush) begin
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_illegal) r_ill_cnt <= r_ill_cnt + CNT_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr   <= r_rd_ptr + PW'(1);
        r_done_cnt <= r_done_cnt + CNT_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible once written.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_res[r_wr_ptr]  <= w_result;
      r_zero[r_wr_ptr] <= w_zero;
      r_ill[r_wr_ptr]  <= w_illegal;
    end
  end
endmodule

// File: tb/tb_logical_issue_unit.sv
// Directed self-checking bench for logical_issue_unit: single ops, back-pressure,
// streaming, illegal/zero results, flush and mid-operation reset.
module tb_logical_issue_unit;
  localparam int W  = 19;
  localparam int OW = 5;
  localparam int CW = 16;

  localparam logic [OW-1:0] OP_AND = 5'd0;
  localparam logic [OW-1:0] OP_OR  = 5'd1;
  localparam logic [OW-1:0] OP_XOR = 5'd2;
  localparam logic [OW-1:0] OP_NOT = 5'd3;
  localparam logic [OW-1:0] OP_ADD = 5'd4;

  logic          clk;
  logic          rst;
  logic [CW-1:0] done_count;
  logic [CW-1:0] illegal_count;

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  logical_issue_unit_if #(.WORD_SIZE(W), .OPCODE_SIZE(OW)) bus ();

  logical_issue_unit #(
    .WORD_SIZE   (W),
    .OPCODE_SIZE (OW),
    .DEPTH       (2),
    .CNT_W       (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus.slave),
    .done_count    (done_count),
    .illegal_count (illegal_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [OW-1:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    bus.req_valid  = v;
    bus.req_opcode = op;
    bus.req_op1    = a;
    bus.req_op2    = b;
  endtask

  task automatic single_op(input string tag, input logic [OW-1:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] exp_r);
    drive(1'b1, op, a, b);
    check_eq({tag, "_ready"}, 32'(bus.req_ready), 1);
    step();
    drive(1'b0, OP_AND, '0, '0);
    check_eq({tag, "_valid"}, 32'(bus.rsp_valid), 1);
    check_eq({tag, "_result"}, 32'(bus.rsp_result), 32'(exp_r));
    check_eq({tag, "_zero"}, 32'(bus.rsp_zero), 0);
    check_eq({tag, "_illegal"}, 32'(bus.rsp_illegal), 0);
    step();
    check_eq({tag, "_drained"}, 32'(bus.rsp_valid), 0);
  endtask

  function automatic logic [W-1:0] model(input logic [OW-1:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    case (op)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_NOT:  return ~a;
      default: return '0;
    endcase
  endfunction

  initial begin
    rst           = 1'b1;
    bus.flush     = 1'b0;
    bus.rsp_ready = 1'b0;
    drive(1'b0, OP_AND, '0, '0);
    step();
    step();
    check_eq("rst_req_ready", 32'(bus.req_ready), 0);
    check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    check_eq("rst_rsp_result", 32'(bus.rsp_result), 0);
    check_eq("rst_done", 32'(done_count), 0);
    check_eq("rst_illegal_cnt", 32'(illegal_count), 0);
    rst = 1'b0;
    #1;
    check_eq("post_rst_ready", 32'(bus.req_ready), 1);

    // single ops, consumer always ready
    bus.rsp_ready = 1'b1;
    single_op("and", OP_AND, 19'h55555, 19'h66666, 19'h44444);
    single_op("or",  OP_OR,  19'h55555, 19'h66666, 19'h77777);
    single_op("xor", OP_XOR, 19'h55555, 19'h66666, 19'h33333);
    single_op("not", OP_NOT, 19'h55555, 19'h66666, 19'h2AAAA);
    check_eq("t1_done", 32'(done_count), 4);

    // back-pressure: two fill the FIFO, third is refused
    bus.rsp_ready = 1'b0;
    drive(1'b1, OP_AND, 19'h55555, 19'h66666);
    check_eq("bp_ready0", 32'(bus.req_ready), 1);
    step();
    drive(1'b1, OP_OR, 19'h55555, 19'h66666);
    check_eq("bp_ready1", 32'(bus.req_ready), 1);
    step();
    drive(1'b1, OP_XOR, 19'h55555, 19'h66666);
    check_eq("bp_full", 32'(bus.req_ready), 0);
    check_eq("bp_hold0", 32'(bus.rsp_result), 32'h44444);
    step();
    check_eq("bp_still_full", 32'(bus.req_ready), 0);
    check_eq("bp_hold1", 32'(bus.rsp_result), 32'h44444);
    drive(1'b0, OP_AND, '0, '0);
    bus.rsp_ready = 1'b1;
    step();
    check_eq("bp_ready_after_pop", 32'(bus.req_ready), 1);
    check_eq("bp_second", 32'(bus.rsp_result), 32'h77777);
    step();
    check_eq("bp_empty", 32'(bus.rsp_valid), 0);
    check_eq("bp_done", 32'(done_count), 6);

    // streaming: push and pop every cycle, pointers wrap several times
    for (int i = 0; i < 8; i++) begin
      logic [OW-1:0] op;
      logic [W-1:0]  a;
      logic [W-1:0]  b;
      op = OW'(i % 4);
      a  = W'(32'h0F0F0 + i * 32'h1357);
      b  = W'(32'h12345 + i * 32'h2468);
      if (i > 0) begin
        check_eq("st_valid", 32'(bus.rsp_valid), 1);
        check_eq("st_result", 32'(bus.rsp_result), 32'(exp_q[0]));
        void'(exp_q.pop_front());
      end
      drive(1'b1, op, a, b);
      check_eq("st_ready", 32'(bus.req_ready), 1);
      exp_q.push_back(model(op, a, b));
      step();
    end
    drive(1'b0, OP_AND, '0, '0);
    check_eq("st_last_valid", 32'(bus.rsp_valid), 1);
    check_eq("st_last_result", 32'(bus.rsp_result), 32'(exp_q[0]));
    void'(exp_q.pop_front());
    step();
    check_eq("st_empty", 32'(bus.rsp_valid), 0);
    check_eq("st_done", 32'(done_count), 14);

    // illegal opcode and a legal zero result
    drive(1'b1, OP_ADD, 19'h12345, 19'h00001);
    step();
    drive(1'b0, OP_AND, '0, '0);
    check_eq("ill_flag", 32'(bus.rsp_illegal), 1);
    check_eq("ill_result", 32'(bus.rsp_result), 0);
    check_eq("ill_zero", 32'(bus.rsp_zero), 1);
    check_eq("ill_count", 32'(illegal_count), 1);
    step();
    drive(1'b1, OP_AND, 19'h7FFFF, 19'h00000);
    step();
    drive(1'b0, OP_AND, '0, '0);
    check_eq("zero_result", 32'(bus.rsp_result), 0);
    check_eq("zero_flag", 32'(bus.rsp_zero), 1);
    check_eq("zero_illegal", 32'(bus.rsp_illegal), 0);
    step();
    check_eq("t4_done", 32'(done_count), 16);

    // flush with a same-cycle illegal request and pop
    bus.rsp_ready = 1'b0;
    drive(1'b1, OP_OR, 19'h00F00, 19'h000F0);
    step();
    step();
    check_eq("fl_full", 32'(bus.req_ready), 0);
    drive(1'b1, OP_ADD, 19'h1, 19'h1);
    bus.rsp_ready = 1'b1;
    bus.flush     = 1'b1;
    step();
    bus.flush     = 1'b0;
    bus.rsp_ready = 1'b0;
    drive(1'b0, OP_AND, '0, '0);
    check_eq("fl_rsp_valid", 32'(bus.rsp_valid), 0);
    check_eq("fl_req_ready", 32'(bus.req_ready), 1);
    check_eq("fl_done", 32'(done_count), 16);
    check_eq("fl_illegal_cnt", 32'(illegal_count), 1);

    // refill (one illegal), then reset mid-operation
    drive(1'b1, OP_ADD, 19'h3, 19'h4);
    step();
    drive(1'b1, OP_XOR, 19'h7FFFF, 19'h0000F);
    step();
    drive(1'b0, OP_AND, '0, '0);
    check_eq("rf_illegal_cnt", 32'(illegal_count), 2);
    check_eq("rf_head_illegal", 32'(bus.rsp_illegal), 1);
    rst = 1'b1;
    step();
    check_eq("mr_req_ready", 32'(bus.req_ready), 0);
    check_eq("mr_rsp_valid", 32'(bus.rsp_valid), 0);
    check_eq("mr_result", 32'(bus.rsp_result), 0);
    check_eq("mr_zero", 32'(bus.rsp_zero), 0);
    check_eq("mr_illegal", 32'(bus.rsp_illegal), 0);
    check_eq("mr_done", 32'(done_count), 0);
    check_eq("mr_illegal_cnt", 32'(illegal_count), 0);
    rst = 1'b0;
    #1;
    check_eq("mr_ready_after", 32'(bus.req_ready), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
